// File: rtl/e_m_pipe_reg.sv
// -----------------------------------------------------------------------------
// e_m_pipe_reg
//
// E->M pipeline register of the five-stage MIPS core. It latches the ALU
// result, store data, destination register, memory-op class, PC and
// branch-delay flag on every rising edge. It also merges the E-stage overflow
// flags into the precise-exception code that is carried to M.
//
// This register owns the bubble, flush and hold behaviour of the M stage.
// CP0 in M consumes m_exc_code, m_pc and m_bd.
//
// Ports
//   clk, reset        : clock; synchronous active-high reset
//   req               : CP0 flush (exception / interrupt / eret)
//   en                : load enable (0 holds every register)
//   e_*               : E-stage instruction fields and overflow flags
//   m_*               : registered M-stage copies of the same fields
// -----------------------------------------------------------------------------
module e_m_pipe_reg #(
  parameter logic [31:0] EXC_HANDLER_PC = 32'h0000_4180,
  parameter logic [4:0]  EXC_OV         = 5'd12,
  parameter logic [4:0]  EXC_ADEL       = 5'd4,
  parameter logic [4:0]  EXC_ADES       = 5'd5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        en,
  input  logic        e_valid,
  input  logic [31:0] e_pc,
  input  logic        e_bd,
  input  logic [4:0]  e_exc_code,
  input  logic [31:0] e_alu_out,
  input  logic [31:0] e_rt_data,
  input  logic [4:0]  e_wreg,
  input  logic        e_is_load,
  input  logic        e_is_store,
  input  logic        e_ov_ari,
  input  logic        e_ov_dm,
  output logic        m_valid,
  output logic [31:0] m_pc,
  output logic        m_bd,
  output logic [4:0]  m_exc_code,
  output logic [31:0] m_alu_out,
  output logic [31:0] m_rt_data,
  output logic [4:0]  m_wreg,
  output logic        m_is_load,
  output logic        m_is_store
);

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic [4:0] merged_code;  // exception code for a real instruction
  logic [4:0] load_code;    // code actually latched (0 for a bubble)
  logic       side_fx_ok;   // instruction may write GPR / touch memory

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    merged_code = 5'd0;
    // An exception raised upstream is older and must win over anything
    // detected here; within E, arithmetic overflow outranks address errors.
    if (e_exc_code != 5'd0) begin
      merged_code = e_exc_code;
    end else if (e_ov_ari) begin
      merged_code = EXC_OV;
    end else if (e_ov_dm && e_is_load) begin
      merged_code = EXC_ADEL;
    end else if (e_ov_dm && e_is_store) begin
      merged_code = EXC_ADES;
    end

    load_code  = e_valid ? merged_code : 5'd0;
    // Bubbles and excepting instructions must not write a GPR or access
    // memory. The ALU result is still latched so that it can feed BadVAddr.
    side_fx_ok = e_valid && (merged_code == 5'd0);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid    <= 1'b0;
      m_pc       <= RESET_PC;
      m_bd       <= 1'b0;
      m_exc_code <= 5'd0;
      m_alu_out  <= 32'd0;
      m_rt_data  <= 32'd0;
      m_wreg     <= 5'd0;
      m_is_load  <= 1'b0;
      m_is_store <= 1'b0;
    end else if (req) begin
      // The flush wins over hold. The PC is parked at the handler so the
      // macroscopic PC seen in M stays defined.
      m_valid    <= 1'b0;
      m_pc       <= EXC_HANDLER_PC;
      m_bd       <= 1'b0;
      m_exc_code <= 5'd0;
      m_alu_out  <= 32'd0;
      m_rt_data  <= 32'd0;
      m_wreg     <= 5'd0;
      m_is_load  <= 1'b0;
      m_is_store <= 1'b0;
    end else if (en) begin
      // A bubble still carries its PC and BD flag so that CP0 can form the
      // EPC for an interrupt taken on it.
      m_valid    <= e_valid;
      m_pc       <= e_pc;
      m_bd       <= e_bd;
      m_exc_code <= load_code;
      m_alu_out  <= e_alu_out;
      m_rt_data  <= e_rt_data;
      m_wreg     <= side_fx_ok ? e_wreg : 5'd0;
      m_is_load  <= side_fx_ok && e_is_load;
      m_is_store <= side_fx_ok && e_is_store;
    end
    // When en is 0, every register holds, including m_exc_code.
  end

endmodule

// File: tb/tb_e_m_pipe_reg.sv
// -----------------------------------------------------------------------------
// tb_e_m_pipe_reg
//
// Self-checking bench for e_m_pipe_reg. The stimulus is directed steps from
// the block's test plan, followed by a randomized run. Expected outputs come
// from a transaction-level model of the M-stage contents, which is updated
// once per clock edge from the block's priority and merge rules.
// -----------------------------------------------------------------------------
module tb_e_m_pipe_reg;

  logic        clk = 1'b0;
  logic        reset, req, en;
  logic        e_valid, e_bd, e_is_load, e_is_store, e_ov_ari, e_ov_dm;
  logic [31:0] e_pc, e_alu_out, e_rt_data;
  logic [4:0]  e_exc_code, e_wreg;
  logic        m_valid, m_bd, m_is_load, m_is_store;
  logic [31:0] m_pc, m_alu_out, m_rt_data;
  logic [4:0]  m_exc_code, m_wreg;

  int n_checks = 0;
  int n_passed = 0;

  always #5 clk = ~clk;

  e_m_pipe_reg dut (
    .clk(clk), .reset(reset), .req(req), .en(en),
    .e_valid(e_valid), .e_pc(e_pc), .e_bd(e_bd), .e_exc_code(e_exc_code),
    .e_alu_out(e_alu_out), .e_rt_data(e_rt_data), .e_wreg(e_wreg),
    .e_is_load(e_is_load), .e_is_store(e_is_store),
    .e_ov_ari(e_ov_ari), .e_ov_dm(e_ov_dm),
    .m_valid(m_valid), .m_pc(m_pc), .m_bd(m_bd), .m_exc_code(m_exc_code),
    .m_alu_out(m_alu_out), .m_rt_data(m_rt_data), .m_wreg(m_wreg),
    .m_is_load(m_is_load), .m_is_store(m_is_store)
  );

  // Expected M-stage contents.
  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic        bd;
    logic [4:0]  code;
    logic [31:0] alu;
    logic [31:0] rt;
    logic [4:0]  wreg;
    logic        ld;
    logic        st;
  } m_state_t;

  m_state_t mdl;

  // Precise-exception code for a real instruction.
  function automatic logic [4:0] exc_of(logic [4:0] up, logic ari, logic dm,
                                        logic ld, logic st);
    if (up != 5'd0)      return up;
    if (ari)             return 5'd12;
    if (dm && ld)        return 5'd4;
    if (dm && st)        return 5'd5;
    return 5'd0;
  endfunction

  // Apply one clock edge to the model using the current inputs.
  task automatic model_edge();
    m_state_t nxt;
    logic [4:0] code;
    bit quiet;
    nxt = mdl;
    if (reset || req) begin
      nxt = '{valid: 1'b0, pc: reset ? 32'h3000 : 32'h4180, bd: 1'b0,
              code: 5'd0, alu: 32'd0, rt: 32'd0, wreg: 5'd0, ld: 1'b0,
              st: 1'b0};
    end else if (en) begin
      code  = e_valid ? exc_of(e_exc_code, e_ov_ari, e_ov_dm, e_is_load,
                               e_is_store) : 5'd0;
      quiet = !e_valid || (code != 5'd0);
      nxt.valid = e_valid;
      nxt.pc    = e_pc;
      nxt.bd    = e_bd;
      nxt.code  = code;
      nxt.alu   = e_alu_out;
      nxt.rt    = e_rt_data;
      nxt.wreg  = quiet ? 5'd0 : e_wreg;
      nxt.ld    = quiet ? 1'b0 : e_is_load;
      nxt.st    = quiet ? 1'b0 : e_is_store;
    end
    mdl = nxt;
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_all(string tag);
    check({tag, ".valid"}, 32'(m_valid),    32'(mdl.valid));
    check({tag, ".pc"},    m_pc,            mdl.pc);
    check({tag, ".bd"},    32'(m_bd),       32'(mdl.bd));
    check({tag, ".code"},  32'(m_exc_code), 32'(mdl.code));
    check({tag, ".alu"},   m_alu_out,       mdl.alu);
    check({tag, ".rt"},    m_rt_data,       mdl.rt);
    check({tag, ".wreg"},  32'(m_wreg),     32'(mdl.wreg));
    check({tag, ".ld"},    32'(m_is_load),  32'(mdl.ld));
    check({tag, ".st"},    32'(m_is_store), 32'(mdl.st));
  endtask

  // One clock: the model follows the DUT edge, and outputs are compared on
  // the following falling edge.
  task automatic step(string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic idle_inputs();
    reset = 0; req = 0; en = 1; e_valid = 1; e_pc = 32'h3000; e_bd = 0;
    e_exc_code = 0; e_alu_out = 0; e_rt_data = 0; e_wreg = 0;
    e_is_load = 0; e_is_store = 0; e_ov_ari = 0; e_ov_dm = 0;
  endtask

  initial begin
    idle_inputs();

    // Reset with every input nonzero, including a competing flush and hold.
    reset = 1; req = 1; en = 0; e_pc = 32'hFFFF_FFFC; e_bd = 1;
    e_exc_code = 5'd3; e_alu_out = 32'hDEAD_BEEF; e_rt_data = 32'hCAFE_F00D;
    e_wreg = 5'd31; e_is_load = 1; e_is_store = 1; e_ov_ari = 1; e_ov_dm = 1;
    step("reset");
    check("reset.pc_const", m_pc, 32'h0000_3000);
    check("reset.valid_const", 32'(m_valid), 32'd0);

    // Overflowing add.
    idle_inputs();
    e_pc = 32'h3010; e_alu_out = 32'h8000_0000; e_wreg = 5'd8; e_ov_ari = 1;
    step("ov_add");
    check("ov_add.code_const", 32'(m_exc_code), 32'd12);
    check("ov_add.wreg_const", 32'(m_wreg), 32'd0);
    check("ov_add.alu_const", m_alu_out, 32'h8000_0000);

    // Store address error, then load, then an older upstream code.
    idle_inputs();
    e_is_store = 1; e_ov_dm = 1; e_wreg = 5'd9;
    step("ades");
    check("ades.code_const", 32'(m_exc_code), 32'd5);
    check("ades.st_const", 32'(m_is_store), 32'd0);
    e_is_store = 0; e_is_load = 1;
    step("adel");
    check("adel.code_const", 32'(m_exc_code), 32'd4);
    e_exc_code = 5'd10; e_ov_ari = 1;
    step("older_exc");
    check("older_exc.code_const", 32'(m_exc_code), 32'd10);

    // Both overflow flags set: arithmetic overflow wins.
    idle_inputs();
    e_is_load = 1; e_ov_ari = 1; e_ov_dm = 1; e_wreg = 5'd4;
    step("both_ov");
    check("both_ov.code_const", 32'(m_exc_code), 32'd12);

    // Clean load passes its side effects through.
    idle_inputs();
    e_is_load = 1; e_wreg = 5'd17; e_alu_out = 32'h1234;
    e_rt_data = 32'h55AA;
    step("load_1234");

    // Hold for three edges with changing inputs.
    en = 0;
    for (int i = 0; i < 3; i++) begin
      e_alu_out = 32'hA000 + 32'(i); e_wreg = 5'(i + 1); e_ov_ari = 1;
      e_pc = 32'h3100 + 32'(4 * i);
      step("hold");
      check("hold.alu_const", m_alu_out, 32'h1234);
    end
    en = 1; e_ov_ari = 0;
    step("release");
    check("release.alu_const", m_alu_out, 32'hA002);

    // Flush and hold on the same edge: flush wins.
    en = 0; req = 1;
    step("flush_hold");
    check("flush.pc_const", m_pc, 32'h0000_4180);
    check("flush.code_const", 32'(m_exc_code), 32'd0);
    req = 0; en = 1;

    // Bubble with a delay-slot flag and a stale overflow.
    idle_inputs();
    e_valid = 0; e_pc = 32'h3020; e_bd = 1; e_ov_ari = 1; e_wreg = 5'd7;
    e_is_store = 1;
    step("bubble");
    check("bubble.pc_const", m_pc, 32'h3020);
    check("bubble.bd_const", 32'(m_bd), 32'd1);
    check("bubble.code_const", 32'(m_exc_code), 32'd0);

    // Reset while holding.
    en = 0; reset = 1;
    step("reset_hold");
    reset = 0; en = 1;

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      reset      = ($urandom_range(0, 39) == 0);
      req        = ($urandom_range(0, 14) == 0);
      en         = ($urandom_range(0, 3) != 0);
      e_valid    = ($urandom_range(0, 4) != 0);
      e_pc       = $urandom & 32'hFFFF_FFFC;
      e_bd       = 1'($urandom);
      e_exc_code = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      e_alu_out  = $urandom;
      e_rt_data  = $urandom;
      e_wreg     = 5'($urandom);
      e_is_load  = 1'($urandom);
      e_is_store = e_is_load ? 1'b0 : 1'($urandom);
      e_ov_ari   = ($urandom_range(0, 5) == 0);
      e_ov_dm    = ($urandom_range(0, 3) == 0);
      step("rand");
    end

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule

// File: doc/e_m_pipe_reg.md
# e_m_pipe_reg

E→M pipeline register of the five-stage MIPS core. Latches the E_ALU result, store data, destination register, control tags, PC and branch-delay flag at each rising edge, and merges the E-stage overflow flags into the precise-exception code carried to M. Owns the bubble/flush/hold behaviour of the M stage; CP0 in M consumes `m_exc_code`, `m_pc` and `m_bd`.

## Interface
Parameters:
- `EXC_HANDLER_PC`, 32'h0000_4180, PC loaded on flush so M-stage macroscopic PC stays defined
- `EXC_OV`, 5'd12, arithmetic overflow code
- `EXC_ADEL`, 5'd4, load address error code
- `EXC_ADES`, 5'd5, store address error code

Ports (clock is `clk`, reset is `reset`; one clock, reset synchronous, active-high):
- `clk`  in  1  clock, all state updates on rising edge
- `reset`  in  1  synchronous active-high reset
- `req`  in  1  exception/interrupt/eret flush from CP0
- `en`  in  1  load enable; 0 holds all state
- `e_valid`  in  1  E stage holds a real instruction (0 = bubble)
- `e_pc`  in  32  E-stage PC
- `e_bd`  in  1  E instruction is in a delay slot
- `e_exc_code`  in  5  exception already raised upstream; 0 = none
- `e_alu_out`  in  32  ALU result / memory address
- `e_rt_data`  in  32  forwarded rt value (store data)
- `e_wreg`  in  5  destination GPR
- `e_is_load`, `e_is_store`  in  1 each  memory-op class
- `e_ov_ari`, `e_ov_dm`  in  1 each  ALU overflow flags
- `m_valid`  out  1
- `m_pc`  out  32
- `m_bd`  out  1
- `m_exc_code`  out  5
- `m_alu_out`, `m_rt_data`  out  32
- `m_wreg`  out  5
- `m_is_load`, `m_is_store`  out  1

## Operation
- Priority per edge: `reset` > `req` > `!en` (hold) > load.
- Reset: all outputs 0 except `m_pc` = 32'h0000_3000.
- Flush (`req`=1): `m_valid`=0, `m_pc`=`EXC_HANDLER_PC`, all other outputs 0; no merge performed.
- Hold (`en`=0): every register keeps its value, including `m_exc_code`.
- Load: data fields copy E inputs; `m_exc_code` = merge:
  - `e_exc_code` ≠ 0 → keep it (older exception wins);
  - else `e_ov_ari` → `EXC_OV`;
  - else `e_ov_dm` & `e_is_load` → `EXC_ADEL`;
  - else `e_ov_dm` & `e_is_store` → `EXC_ADES`;
  - else 0.
- Bubble (`e_valid`=0) on load: `m_exc_code` forced 0, `m_wreg`=0, `m_is_load`=`m_is_store`=0; `m_pc`, `m_bd` still copied (bubble keeps PC for CP0 EPC).
- Instruction with nonzero merged code: `m_wreg` forced 0, `m_is_load`/`m_is_store` forced 0 (no side effects in M/W); `m_alu_out` still copied for BadVAddr.
- `e_ov_ari` and `e_ov_dm` both high: `EXC_OV` chosen.

## Timing
- Latency 1 cycle: inputs sampled at edge N appear on outputs after edge N, stable through cycle N+1.
- All outputs registered; no combinational path from input to output.
- `req` and `en`=0 same cycle: flush wins.
- `reset` mid-hold or mid-flush: reset values next edge.
- Flush lasts exactly the cycles `req` is high; first `req`=0 edge with `en`=1 loads normally.

## Test plan
- Reset: assert `reset` with all inputs nonzero → next edge `m_pc`=0x3000, all other outputs 0, `m_valid`=0.
- Overflow add: `e_valid`=1, `e_pc`=0x3010, `e_alu_out`=0x8000_0000, `e_wreg`=8, `e_ov_ari`=1 → `m_exc_code`=12, `m_wreg`=0, `m_alu_out`=0x8000_0000, `m_pc`=0x3010.
- Address overflow: `e_is_store`=1, `e_ov_dm`=1, `e_exc_code`=0 → `m_exc_code`=5, `m_is_store`=0; repeat with `e_is_load`=1 → 4; with `e_exc_code`=10 and `e_ov_ari`=1 → 10.
- Hold: load `e_alu_out`=0x1234, then `en`=0 with new inputs for 3 edges → outputs stay 0x1234; `en`=1 → new values next edge.
- Flush vs hold: `en`=0 and `req`=1 same edge → `m_valid`=0, `m_pc`=0x4180, `m_exc_code`=0.
- Bubble: `e_valid`=0, `e_pc`=0x3020, `e_bd`=1, `e_ov_ari`=1 → `m_exc_code`=0, `m_wreg`=0, `m_pc`=0x3020, `m_bd`=1.
